cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of each performance counter.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 mem_read / mem_write  input  1 each  CPU request strobes, held until mem_resp.
REQ-005 mem_byte_enable256  input  32  CPU write byte enables.
REQ-006 mem_resp  output  1  one-cycle CPU completion pulse.
REQ-007 pmem_read / pmem_write  output  1 each  memory requests, held until pmem_resp.
REQ-008 pmem_resp  input  1  memory completion pulse.
REQ-009 hit_way0, hit_way1, dataout_valid0/1, dataout_dirty0/1, dataout_lru  input  1 each  datapath status.
REQ-010 read_valid, read_dirty, read_tag  output  2 each  per-way array read enables; read_lru output 1.
REQ-011 load_valid, load_dirty, load_tag, load_data  output  2 each  per-way array loads; load_lru output 1.
REQ-012 datain_valid, datain_dirty  output  2 each; datain_lru  output 1  array write values.
REQ-013 data0_mem_byte_enable, data1_mem_byte_enable  output  32 each  data write enables.
REQ-014 allocate_way0, allocate_way1, pmem_addr  output  1 each  datapath mux selects.
REQ-015 hit_count, miss_count, wb_count  output  CNT_WIDTH each  performance counters.

Function
REQ-016 States: IDLE, CHECK, WRITEBACK, ALLOCATE, RELOAD; any unlisted output is 0 by default.
REQ-017 IDLE: on mem_read|mem_write assert all read_* enables, go CHECK; else stay.
REQ-018 CHECK hit (way0 priority if both): mem_resp=1 same cycle, load_lru=1, datain_lru = index of the non-hit way, go IDLE; hit latency 2 cycles from request.
REQ-019 CHECK write hit: additionally hit way's data byte enable = mem_byte_enable256, load_dirty/datain_dirty=1 for that way.
REQ-020 CHECK miss: victim = dataout_lru; victim valid and dirty -> WRITEBACK, else ALLOCATE.
REQ-021 WRITEBACK: pmem_write=1, pmem_addr=1; on pmem_resp go ALLOCATE.
REQ-022 ALLOCATE: pmem_read=1, allocate_way<victim>=1; on pmem_resp: victim byte enable = all ones, load_tag, load_valid (1), load_dirty (0) for victim, go RELOAD.
REQ-023 RELOAD: assert all read_* enables, go CHECK (guaranteed hit).
REQ-024 pmem_read and pmem_write never asserted together; victim latched at CHECK exit, stable through WRITEBACK/ALLOCATE.
REQ-025 mem_read and mem_write both high: treated as write.
REQ-026 CPU strobes dropped mid-miss: outstanding pmem transaction completes, fill completes, return IDLE via RELOAD/CHECK with no mem_resp.
REQ-027 Non-hit way never written; mem_resp exactly once per accepted request.

Reset
REQ-028 rst=0 immediately forces IDLE, victim=0, all outputs 0, counters 0, regardless of clock or pending pmem transaction.
REQ-029 Release of rst takes effect on next rising clk; first request accepted that cycle.

Configuration
REQ-030 Macro CACHE_PERF_CNT_EN defined: hit_count +1 per CHECK hit excluding post-RELOAD hits, miss_count +1 per CHECK miss, wb_count +1 per WRITEBACK pmem_resp; counters wrap modulo 2^CNT_WIDTH.
REQ-031 Macro undefined: counter registers absent, hit_count/miss_count/wb_count tied to 0; FSM behaviour identical.

Verification
REQ-032 Read miss, empty set, index 3: ALLOCATE, pmem_read until pmem_resp (5-cycle mem), way0 valid=1, dirty=0, mem_resp once; miss_count=1, wb_count=0.
REQ-033 Repeat read to same address: mem_resp 2 cycles after request, no pmem activity, LRU written 1; hit_count=1.
REQ-034 Write hit, byte enable 0x0000000F: data0_mem_byte_enable=0x0000000F one cycle, dirty0=1, data1 enables 0.
REQ-035 Fill both ways dirty, third tag to same set: WRITEBACK (pmem_write, pmem_addr=1) then ALLOCATE into LRU way; wb_count=1.
REQ-036 rst=0 asserted mid-WRITEBACK: pmem_write drops before next clk edge, state IDLE, counters 0.
REQ-037 Counter wrap: CNT_WIDTH=4, 17 hits -> hit_count=1; build without CACHE_PERF_CNT_EN -> all counters 0.

Source files
------------

// File: rtl/cache_control_if.sv
// cache_control_if: CPU and physical-memory handshake bundle for cache_control.
//   mem_read, mem_write     CPU request strobes, held until mem_resp
//   mem_byte_enable256      CPU write byte enables
//   mem_resp                one-cycle CPU completion pulse
//   pmem_read, pmem_write   memory requests, held until pmem_resp
//   pmem_resp               memory completion pulse
// Modports:
//   slave  - the controller side
//   master - the environment side (CPU plus memory)
interface cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_byte_enable256;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable256, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable256, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// cache_control: two-way write-back cache controller FSM.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   bus                   CPU / memory handshakes (cache_control_if.slave)
//   hit_way*, dataout_*   datapath tag-compare and array status
//   read_*, load_*        array read enables and per-way load strobes
//   datain_*              values written into the status arrays
//   data*_mem_byte_enable per-way data array write enables
//   allocate_way*, pmem_addr  datapath mux selects
//   hit/miss/wb_count     performance counters (CNT_WIDTH bits)
// Build option: define CACHE_PERF_CNT_EN to include the performance counters;
// without it the counter outputs are tied to zero.
//
// state     | meaning
// IDLE      | waiting for a CPU request
// CHECK     | tag compare; respond on hit, pick victim on miss
// WRITEBACK | writing the dirty victim line to memory
// ALLOCATE  | fetching the missing line into the victim way
// RELOAD    | re-reading arrays so CHECK sees the fresh line
module cache_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_control_if.slave       bus,
  input  logic                 hit_way0,
  input  logic                 hit_way1,
  input  logic                 dataout_valid0,
  input  logic                 dataout_valid1,
  input  logic                 dataout_dirty0,
  input  logic                 dataout_dirty1,
  input  logic                 dataout_lru,
  output logic [1:0]           read_valid,
  output logic [1:0]           read_dirty,
  output logic [1:0]           read_tag,
  output logic                 read_lru,
  output logic [1:0]           load_valid,
  output logic [1:0]           load_dirty,
  output logic [1:0]           load_tag,
  output logic [1:0]           load_data,
  output logic                 load_lru,
  output logic [1:0]           datain_valid,
  output logic [1:0]           datain_dirty,
  output logic                 datain_lru,
  output logic [31:0]          data0_mem_byte_enable,
  output logic [31:0]          data1_mem_byte_enable,
  output logic                 allocate_way0,
  output logic                 allocate_way1,
  output logic                 pmem_addr,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, ALLOCATE, RELOAD} state_t;

  state_t state, state_next;
  logic   victim, victim_next;
  logic   req, hit, hit_way, victim_valid, victim_dirty;

  assign req          = bus.mem_read | bus.mem_write;
  assign hit          = hit_way0 | hit_way1;
  assign hit_way      = ~hit_way0;  // way0 wins when both ways match
  assign victim_valid = dataout_lru ? dataout_valid1 : dataout_valid0;
  assign victim_dirty = dataout_lru ? dataout_dirty1 : dataout_dirty0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state  <= state_next;
      victim <= victim_next;
    end
  end

  // Outputs are gated by rst so they read zero for the whole time reset is
  // held, even while the CPU keeps its strobes up.
  always_comb begin
    state_next            = state;
    victim_next           = victim;
    read_valid            = 2'b00;
    read_dirty            = 2'b00;
    read_tag              = 2'b00;
    read_lru              = 1'b0;
    load_valid            = 2'b00;
    load_dirty            = 2'b00;
    load_tag              = 2'b00;
    load_data             = 2'b00;
    load_lru              = 1'b0;
    datain_valid          = 2'b00;
    datain_dirty          = 2'b00;
    datain_lru            = 1'b0;
    data0_mem_byte_enable = 32'h0;
    data1_mem_byte_enable = 32'h0;
    allocate_way0         = 1'b0;
    allocate_way1         = 1'b0;
    pmem_addr             = 1'b0;
    bus.mem_resp          = 1'b0;
    bus.pmem_read         = 1'b0;
    bus.pmem_write        = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            read_valid = 2'b11;
            read_dirty = 2'b11;
            read_tag   = 2'b11;
            read_lru   = 1'b1;
            state_next = CHECK;
          end
        end
        CHECK: begin
          if (!req) begin
            // CPU gave up during a miss: finish silently
            state_next = IDLE;
          end else if (hit) begin
            bus.mem_resp = 1'b1;
            load_lru     = 1'b1;
            datain_lru   = ~hit_way;
            if (bus.mem_write) begin
              load_dirty[hit_way]   = 1'b1;
              datain_dirty[hit_way] = 1'b1;
              load_data[hit_way]    = 1'b1;
              if (hit_way) data1_mem_byte_enable = bus.mem_byte_enable256;
              else         data0_mem_byte_enable = bus.mem_byte_enable256;
            end
            state_next = IDLE;
          end else begin
            victim_next = dataout_lru;
            state_next  = (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          bus.pmem_write = 1'b1;
          pmem_addr      = 1'b1;
          if (bus.pmem_resp) state_next = ALLOCATE;
        end
        ALLOCATE: begin
          bus.pmem_read = 1'b1;
          allocate_way0 = ~victim;
          allocate_way1 = victim;
          if (bus.pmem_resp) begin
            load_tag[victim]     = 1'b1;
            load_valid[victim]   = 1'b1;
            datain_valid[victim] = 1'b1;
            load_dirty[victim]   = 1'b1;
            load_data[victim]    = 1'b1;
            if (victim) data1_mem_byte_enable = 32'hFFFF_FFFF;
            else        data0_mem_byte_enable = 32'hFFFF_FFFF;
            state_next = RELOAD;
          end
        end
        RELOAD: begin
          read_valid = 2'b11;
          read_dirty = 2'b11;
          read_tag   = 2'b11;
          read_lru   = 1'b1;
          state_next = CHECK;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 from_reload;
  logic [CNT_WIDTH-1:0] hit_q, miss_q, wb_q;

  // RELOAD lasts exactly one cycle, so a registered copy of it marks the
  // CHECK that follows a fill; that hit is not a real cache hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      from_reload <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      wb_q        <= '0;
    end else begin
      from_reload <= (state == RELOAD);
      if (state == CHECK && req && hit && !from_reload) hit_q <= hit_q + CNT_ONE;
      if (state == CHECK && req && !hit) miss_q <= miss_q + CNT_ONE;
      if (state == WRITEBACK && bus.pmem_resp) wb_q <= wb_q + CNT_ONE;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
`timescale 1ns/1ps
module tb_cache_control;
  localparam int CW      = 4;
  localparam int MEM_LAT = 5;
`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_control_if bus();

  logic          hit_way0, hit_way1, dataout_valid0, dataout_valid1;
  logic          dataout_dirty0, dataout_dirty1, dataout_lru;
  logic [1:0]    read_valid, read_dirty, read_tag;
  logic          read_lru;
  logic [1:0]    load_valid, load_dirty, load_tag, load_data;
  logic          load_lru;
  logic [1:0]    datain_valid, datain_dirty;
  logic          datain_lru;
  logic [31:0]   data0_mem_byte_enable, data1_mem_byte_enable;
  logic          allocate_way0, allocate_way1, pmem_addr;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit_way0(hit_way0), .hit_way1(hit_way1),
    .dataout_valid0(dataout_valid0), .dataout_valid1(dataout_valid1),
    .dataout_dirty0(dataout_dirty0), .dataout_dirty1(dataout_dirty1),
    .dataout_lru(dataout_lru),
    .read_valid(read_valid), .read_dirty(read_dirty), .read_tag(read_tag), .read_lru(read_lru),
    .load_valid(load_valid), .load_dirty(load_dirty), .load_tag(load_tag),
    .load_data(load_data), .load_lru(load_lru),
    .datain_valid(datain_valid), .datain_dirty(datain_dirty), .datain_lru(datain_lru),
    .data0_mem_byte_enable(data0_mem_byte_enable), .data1_mem_byte_enable(data1_mem_byte_enable),
    .allocate_way0(allocate_way0), .allocate_way1(allocate_way1), .pmem_addr(pmem_addr),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  // ---------------- datapath / memory environment ----------------
  bit         env_v   [8][2];
  bit         env_d   [8][2];
  logic [3:0] env_t   [8][2];
  bit         env_lru [8];
  logic [2:0] cur_set = 3'd0;
  logic [3:0] cur_tag = 4'd0;

  assign hit_way0       = env_v[cur_set][0] && (env_t[cur_set][0] == cur_tag);
  assign hit_way1       = env_v[cur_set][1] && (env_t[cur_set][1] == cur_tag);
  assign dataout_valid0 = env_v[cur_set][0];
  assign dataout_valid1 = env_v[cur_set][1];
  assign dataout_dirty0 = env_d[cur_set][0];
  assign dataout_dirty1 = env_d[cur_set][1];
  assign dataout_lru    = env_lru[cur_set];

  logic [1:0]  c_lv, c_ld, c_lt, c_dv, c_dd;
  logic        c_ll, c_dl, c_pr, c_pw;
  logic [2:0]  c_set;
  logic [3:0]  c_tag;
  int          mem_cnt, rd_txn, wb_txn, resp_total, both_err;
  int          be_n [2];
  logic [31:0] be_last [2];

  initial begin
    for (int s = 0; s < 8; s++) begin
      env_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        env_v[s][w] = 1'b0; env_d[s][w] = 1'b0; env_t[s][w] = 4'd0;
      end
    end
    {c_lv, c_ld, c_lt, c_dv, c_dd, c_ll, c_dl, c_pr, c_pw} = '0;
    c_set = '0; c_tag = '0;
    mem_cnt = 0; rd_txn = 0; wb_txn = 0; resp_total = 0; both_err = 0;
    be_n[0] = 0; be_n[1] = 0; be_last[0] = '0; be_last[1] = '0;
    bus.pmem_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        bus.pmem_resp = 1'b0;
        mem_cnt = 0;
      end else begin
        for (int w = 0; w < 2; w++) begin
          if (c_lv[w]) env_v[c_set][w] = c_dv[w];
          if (c_ld[w]) env_d[c_set][w] = c_dd[w];
          if (c_lt[w]) env_t[c_set][w] = c_tag;
        end
        if (c_ll) env_lru[c_set] = c_dl;
        if (bus.pmem_resp) begin
          bus.pmem_resp = 1'b0;
          mem_cnt = 0;
        end else if (c_pr || c_pw) begin
          mem_cnt++;
          if (mem_cnt == MEM_LAT - 1) begin
            bus.pmem_resp = 1'b1;
            if (c_pw) wb_txn++; else rd_txn++;
          end
        end
      end
      @(negedge clk);
      if (rst) begin
        c_lv = load_valid; c_ld = load_dirty; c_lt = load_tag;
        c_dv = datain_valid; c_dd = datain_dirty;
        c_ll = load_lru; c_dl = datain_lru;
        c_pr = bus.pmem_read; c_pw = bus.pmem_write;
        c_set = cur_set; c_tag = cur_tag;
        if (bus.pmem_read && bus.pmem_write) both_err++;
        if (bus.mem_resp) resp_total++;
        if (data0_mem_byte_enable != 32'h0) begin be_n[0]++; be_last[0] = data0_mem_byte_enable; end
        if (data1_mem_byte_enable != 32'h0) begin be_n[1]++; be_last[1] = data1_mem_byte_enable; end
      end else begin
        {c_lv, c_ld, c_lt, c_dv, c_dd, c_ll, c_dl, c_pr, c_pw} = '0;
      end
    end
  end

  // ---------------- reference model: plain 2-way LRU write-back cache ----------------
  bit          rv [8][2];
  bit          rdt[8][2];
  int          rtg[8][2];
  bit          rl [8];
  int          m_hits, m_miss, m_wb;
  bit          m_hit;
  int          m_wbf;
  int          e_n [2];
  logic [31:0] e_l [2];

  task automatic model_access(input int s, input int t, input bit wr, input logic [31:0] be);
    int w;
    e_n[0] = 0; e_n[1] = 0; m_wbf = 0;
    if (rv[s][0] && rtg[s][0] == t)      begin m_hit = 1'b1; w = 0; end
    else if (rv[s][1] && rtg[s][1] == t) begin m_hit = 1'b1; w = 1; end
    else                                 begin m_hit = 1'b0; w = int'(rl[s]); end
    if (m_hit) m_hits++;
    else begin
      m_miss++;
      if (rv[s][w] && rdt[s][w]) begin m_wbf = 1; m_wb++; end
      rv[s][w] = 1'b1; rdt[s][w] = 1'b0; rtg[s][w] = t;
      e_n[w] = 1; e_l[w] = 32'hFFFF_FFFF;
    end
    rl[s] = (w == 0);
    if (wr) begin
      rdt[s][w] = 1'b1;
      if (be != 32'h0) begin e_n[w]++; e_l[w] = be; end
    end
  endtask

  function automatic logic [15:0] env_pack(input int s);
    return {env_v[s][0], env_v[s][1], env_d[s][0], env_d[s][1], env_lru[s], 3'b000,
            env_t[s][0], env_t[s][1]};
  endfunction

  function automatic logic [15:0] model_pack(input int s);
    return {rv[s][0], rv[s][1], rdt[s][0], rdt[s][1], rl[s], 3'b000,
            4'(rtg[s][0]), 4'(rtg[s][1])};
  endfunction

  function automatic logic [CW-1:0] ec(input int m);
    return PERF ? CW'(m) : '0;
  endfunction

  function automatic logic [63:0] ctl_outs();
    return {37'd0, read_valid, read_dirty, read_tag, read_lru, load_valid, load_dirty,
            load_tag, load_data, load_lru, datain_valid, datain_dirty, datain_lru,
            allocate_way0, allocate_way1, pmem_addr, bus.mem_resp, bus.pmem_read, bus.pmem_write};
  endfunction

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_count"},  hit_count,  ec(m_hits));
    check({tag, "_miss_count"}, miss_count, ec(m_miss));
    check({tag, "_wb_count"},   wb_count,   ec(m_wb));
  endtask

  bit o_hit;
  int o_wb;

  task automatic run_txn(input int s, input int t, input bit rd, input bit wr, input logic [31:0] be);
    int s_rd, s_wb, s_resp, s_be0, s_be1, lat;
    bit got;
    @(posedge clk); #1;
    s_rd = rd_txn; s_wb = wb_txn; s_resp = resp_total; s_be0 = be_n[0]; s_be1 = be_n[1];
    cur_set = 3'(s); cur_tag = 4'(t);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_byte_enable256 = be;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk); lat++;
      if (bus.mem_resp) got = 1'b1;
    end
    check("mem_resp_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    model_access(s, t, wr, be);
    o_hit = (rd_txn == s_rd) && (wb_txn == s_wb);
    o_wb  = wb_txn - s_wb;
    check("txn_hit",         64'(o_hit), 64'(m_hit));
    check("pmem_reads",      64'(rd_txn - s_rd), m_hit ? 64'd0 : 64'd1);
    check("writebacks",      64'(o_wb), 64'(m_wbf));
    check("mem_resp_pulses", 64'(resp_total - s_resp), 64'd1);
    if (m_hit) check("hit_latency", 64'(lat), 64'd2);
    check("array_state",     64'(env_pack(s)), 64'(model_pack(s)));
    check("data0_be_writes", 64'(be_n[0] - s_be0), 64'(e_n[0]));
    check("data1_be_writes", 64'(be_n[1] - s_be1), 64'(e_n[1]));
    if (e_n[0] > 0) check("data0_be_value", 64'(be_last[0]), 64'(e_l[0]));
    if (e_n[1] > 0) check("data1_be_value", 64'(be_last[1]), 64'(e_l[1]));
    check_counters("txn");
  endtask

  typedef struct {
    int          set;
    int          tag;
    bit          rd;
    bit          wr;
    logic [31:0] be;
    bit          exp_hit;
    int          exp_wb;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #900000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, s_rd, s_resp, s_be0, op;
    tbl[0] = '{3, 1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 0};  // cold read miss, way0 filled
    tbl[1] = '{3, 1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 0};  // read hit, LRU -> 1
    tbl[2] = '{3, 1, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 0};  // write hit way0
    tbl[3] = '{3, 2, 1'b0, 1'b1, 32'h0000_FF00, 1'b0, 0};  // write miss into empty way1
    tbl[4] = '{3, 3, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1};  // both dirty: writeback way0
    tbl[5] = '{3, 2, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 0};  // read hit way1
    tbl[6] = '{5, 4, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 0};  // read+write strobes: write miss
    tbl[7] = '{5, 4, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 0};
    m_hits = 0; m_miss = 0; m_wb = 0;
    for (int s = 0; s < 8; s++) begin
      rl[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin rv[s][w] = 1'b0; rdt[s][w] = 1'b0; rtg[s][w] = 0; end
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable256 = 32'h0;

    // reset state, including strobes held high while in reset
    repeat (2) @(negedge clk);
    check("rst_ctrl_outputs", ctl_outs(), 64'd0);
    check("rst_byte_enables", {data0_mem_byte_enable, data1_mem_byte_enable}, 64'd0);
    check_counters("rst");
    bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.mem_byte_enable256 = 32'hFFFF_FFFF;
    #1;
    check("rst_outputs_with_req", ctl_outs(), 64'd0);
    check("rst_byte_enables_with_req", {data0_mem_byte_enable, data1_mem_byte_enable}, 64'd0);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].set, tbl[i].tag, tbl[i].rd, tbl[i].wr, tbl[i].be);
      check("tbl_hit", 64'(o_hit), 64'(tbl[i].exp_hit));
      check("tbl_writebacks", 64'(o_wb), 64'(tbl[i].exp_wb));
    end

    // CPU abandons a read miss while the fill is in flight
    @(posedge clk); #1;
    s_rd = rd_txn; s_resp = resp_total; s_be0 = be_n[0];
    cur_set = 3'd7; cur_tag = 4'd9;
    bus.mem_read = 1'b1;
    n = 0;
    while (!bus.pmem_read && n < 20) begin @(negedge clk); n++; end
    check("drop_fill_started", 64'(bus.pmem_read), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    n = 0;
    while (rd_txn == s_rd && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    m_miss++;
    rv[7][0] = 1'b1; rdt[7][0] = 1'b0; rtg[7][0] = 9;  // victim way0, LRU untouched
    check("drop_pmem_reads", 64'(rd_txn - s_rd), 64'd1);
    check("drop_no_mem_resp", 64'(resp_total - s_resp), 64'd0);
    check("drop_array_state", 64'(env_pack(7)), 64'(model_pack(7)));
    check("drop_fill_be", 64'(be_n[0] - s_be0), 64'd1);
    check("drop_back_idle", ctl_outs(), 64'd0);
    check_counters("drop");

    // reset asserted in the middle of a writeback
    run_txn(6, 1, 1'b0, 1'b1, 32'hF0F0_0000);
    run_txn(6, 2, 1'b0, 1'b1, 32'h0000_0001);
    @(posedge clk); #1;
    cur_set = 3'd6; cur_tag = 4'd3;
    bus.mem_read = 1'b1;
    n = 0;
    while (!bus.pmem_write && n < 20) begin @(negedge clk); n++; end
    check("wb_started", 64'(bus.pmem_write), 64'd1);
    check("wb_pmem_addr", 64'(pmem_addr), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_wb_pmem_write", 64'(bus.pmem_write), 64'd0);
    check("rst_mid_wb_outputs", ctl_outs(), 64'd0);
    m_hits = 0; m_miss = 0; m_wb = 0;
    check_counters("rst_mid_wb");
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_txn(6, 3, 1'b1, 1'b0, 32'h0);
    check("post_rst_writeback", 64'(o_wb), 64'd1);

    // randomized traffic over a few sets and tags; enough hits to wrap the counters
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 2));
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              op != 1, op != 0, $urandom | 32'h1);
    end

    check("pmem_rd_wr_overlap", 64'(both_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
